// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: shared types, constants and helpers for the AES SPI master.
//   state_t    - FSM state encoding
//   NK_*       - legal key lengths in 32-bit words
//   nk_legal() - true for a supported key length
//   frame_len()- total frame length in bits (data block + key)
package aes_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        HOLD,
        DONE
    } state_t;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;

    function automatic logic nk_legal(input logic [3:0] nk);
        return (nk == NK_128) || (nk == NK_192) || (nk == NK_256);
    endfunction

    // 32 * nk expressed as a shift so the result stays 9 bits wide.
    function automatic logic [8:0] frame_len(input logic [3:0] nk,
                                             input int unsigned data_w = 128);
        return 9'(data_w) + {nk, 5'b00000};
    endfunction

endpackage

// File: rtl/aes_spi_master_if.sv
// aes_spi_master_if: control and SPI bus signals of the AES SPI master.
//   control : start, abort, nk, data_in, key_in          (to master)
//   status  : busy, done, err, rx_data, led              (from master)
//   spi     : sclk, mosi, ss_n (from master), miso (to master)
// modport master is the controller side, modport slave the surrounding logic.
interface aes_spi_master_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned KEY_W  = 256
);

    logic              start;
    logic              abort;
    logic [3:0]        nk;
    logic [DATA_W-1:0] data_in;
    logic [KEY_W-1:0]  key_in;
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic              ss_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rx_data;
    logic              led;

    modport master (
        input  start, abort, nk, data_in, key_in, miso,
        output sclk, mosi, ss_n, busy, done, err, rx_data, led
    );

    modport slave (
        output start, abort, nk, data_in, key_in, miso,
        input  sclk, mosi, ss_n, busy, done, err, rx_data, led
    );

endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period timer for the SPI clock.
//   clock, reset : system clock, synchronous active-low reset
//   en           : count while high; counter held at 0 otherwise
//   phase        : current sclk level, selects which strobe fires
//   rise_stb     : half-period elapsed while sclk is low
//   fall_stb     : half-period elapsed while sclk is high
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic phase,
    output logic rise_stb,
    output logic fall_stb
);

    logic [7:0] cnt_q;
    logic       tick;

    assign tick = en && (cnt_q == 8'(CLK_DIV - 1));

    // Wraps to 0 on every strobe so each half-period restarts cleanly.
    always_ff @(posedge clock) begin
        if (!reset || !en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    always_comb begin
        rise_stb = tick && !phase;
        fall_stb = tick &&  phase;
    end

endmodule

// File: rtl/aes_spi_master.sv
// aes_spi_master: SPI mode-0 master sending one AES frame (data block then
// Nk key words, MSB first) and capturing the last DATA_W bits of MISO.
//   clock, reset : system clock, synchronous active-low reset
//   bus          : aes_spi_master_if.master (control, status and SPI pins)
// Parameters: CLK_DIV system clocks per sclk half-period (1..255),
// DATA_W data width, KEY_W key input width (32 x max Nk).
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned KEY_W   = 256
) (
    input  logic             clock,
    input  logic             reset,
    aes_spi_master_if.master bus
);

    localparam int unsigned FRAME_W = DATA_W + KEY_W;

    state_t             state;
    logic [FRAME_W-1:0] tx_sh;
    logic [DATA_W-1:0]  rx_sh;
    logic [8:0]         bit_cnt;
    logic [8:0]         last_bit;

    logic               sclk_q;
    logic               mosi_q;
    logic               ss_n_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [DATA_W-1:0]  rx_q;
    logic               led_q;

    logic               clk_en;
    logic               rise_stb;
    logic               fall_stb;

    assign clk_en = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == HOLD);

    // In HOLD sclk is low, so rise_stb doubles as the end-of-hold strobe.
    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clock    (clock),
        .reset    (reset),
        .en       (clk_en),
        .phase    (sclk_q),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
            last_bit <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ss_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rx_q     <= '0;
            led_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if ((state != IDLE) && bus.abort) begin
                // Abort drops the frame at once; rx_data keeps its old value.
                state  <= IDLE;
                sclk_q <= 1'b0;
                mosi_q <= 1'b0;
                ss_n_q <= 1'b1;
                busy_q <= 1'b0;
                err_q  <= 1'b1;
                led_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            if (nk_legal(bus.nk)) begin
                                tx_sh    <= {bus.data_in, bus.key_in};
                                rx_sh    <= '0;
                                bit_cnt  <= '0;
                                last_bit <= frame_len(bus.nk, DATA_W) - 9'd1;
                                mosi_q   <= bus.data_in[DATA_W-1];
                                sclk_q   <= 1'b0;
                                ss_n_q   <= 1'b0;
                                busy_q   <= 1'b1;
                                state    <= SHIFT_LO;
                            end else begin
                                err_q <= 1'b1;
                                led_q <= 1'b0;
                            end
                        end
                    end
                    SHIFT_LO: begin
                        if (rise_stb) begin
                            sclk_q <= 1'b1;
                            rx_sh  <= {rx_sh[DATA_W-2:0], bus.miso};
                            state  <= SHIFT_HI;
                        end
                    end
                    SHIFT_HI: begin
                        if (fall_stb) begin
                            sclk_q <= 1'b0;
                            if (bit_cnt == last_bit) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 9'd1;
                                tx_sh   <= tx_sh << 1;
                                mosi_q  <= tx_sh[FRAME_W-2];
                                state   <= SHIFT_LO;
                            end
                        end
                    end
                    HOLD: begin
                        if (rise_stb) begin
                            ss_n_q <= 1'b1;
                            mosi_q <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            rx_q   <= rx_sh;
                            led_q  <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.ss_n    = ss_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.rx_data = rx_q;
    assign bus.led     = led_q;

endmodule

// File: tb/tb_aes_spi_master.sv
// tb_aes_spi_master: scoreboard bench for aes_spi_master. Stimulus pushes the
// expected done/err outcome into a per-DUT queue; a monitor pops and compares
// whenever the DUT pulses done or err. dut_a runs CLK_DIV=2, dut_b CLK_DIV=1.
module tb_aes_spi_master;
    import aes_spi_pkg::*;

    typedef struct packed {
        logic         is_err;
        logic [127:0] rx;
        logic         led;
    } exp_t;

    localparam logic [127:0] DATA1  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [255:0] KEY    =
        256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] RX_K4  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] RX_K6  = 128'h08090A0B0C0D0E0F1011121314151617;
    localparam logic [127:0] ONES   = {128{1'b1}};

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    aes_spi_master_if #(.DATA_W(128), .KEY_W(256)) bus_a ();
    aes_spi_master_if #(.DATA_W(128), .KEY_W(256)) bus_b ();

    aes_spi_master #(.CLK_DIV(2), .DATA_W(128), .KEY_W(256)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    aes_spi_master #(.CLK_DIV(1), .DATA_W(128), .KEY_W(256)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    // 0: loopback, 1: tied high, 2: tied low
    logic [1:0] miso_mode_a;
    assign bus_a.miso = (miso_mode_a == 2'd0) ? bus_a.mosi : (miso_mode_a == 2'd1);
    assign bus_b.miso = bus_b.mosi;

    int   cyc    = 0;
    int   rise_a = 0;
    int   rise_b = 0;
    int   low_a  = 0;
    logic sclk_prev_a = 1'b0;
    logic sclk_prev_b = 1'b0;

    always @(posedge clock) begin
        cyc         <= cyc + 1;
        sclk_prev_a <= bus_a.sclk;
        sclk_prev_b <= bus_b.sclk;
        if (bus_a.sclk && !sclk_prev_a) rise_a <= rise_a + 1;
        if (bus_b.sclk && !sclk_prev_b) rise_b <= rise_b + 1;
        if (!bus_a.ss_n) low_a <= low_a + 1;
    end

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   ev_a     = 0;
    int   ev_b     = 0;
    int   ev_cyc_a = 0;
    int   ev_cyc_b = 0;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mon(input bit sel);
        exp_t         e;
        logic         d;
        logic         er;
        logic         ld;
        logic [127:0] rx;
        int           qs;
        forever begin
            @(negedge clock);
            d  = sel ? bus_b.done    : bus_a.done;
            er = sel ? bus_b.err     : bus_a.err;
            ld = sel ? bus_b.led     : bus_a.led;
            rx = sel ? bus_b.rx_data : bus_a.rx_data;
            if (d || er) begin
                if (sel) begin ev_b++; ev_cyc_b = cyc; end
                else     begin ev_a++; ev_cyc_a = cyc; end
                qs = sel ? q_b.size() : q_a.size();
                if (qs == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL %s_unexpected: got done=%b err=%b, expected no event",
                             sel ? "b" : "a", d, er);
                end else begin
                    if (sel) e = q_b.pop_front();
                    else     e = q_a.pop_front();
                    chk(sel ? "b_err"  : "a_err",  128'(er), 128'(e.is_err));
                    chk(sel ? "b_done" : "a_done", 128'(d),  128'(!e.is_err));
                    chk(sel ? "b_rx"   : "a_rx",   rx,       e.rx);
                    chk(sel ? "b_led"  : "a_led",  128'(ld), 128'(e.led));
                end
            end
        end
    endtask

    task automatic wait_ev(input bit sel, input int base, input int limit, input string name);
        int n;
        n = 0;
        while (((sel ? ev_b : ev_a) == base) && (n < limit)) begin
            tick();
            n++;
        end
        if ((sel ? ev_b : ev_a) == base) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no done/err in %0d cycles, expected one", name, limit);
        end
    endtask

    task automatic wait_rise_a(input int r0, input int bits, input string name);
        int n;
        n = 0;
        while ((rise_a - r0 < bits) && (n < 4000)) begin
            tick();
            n++;
        end
        chk(name, 128'(rise_a - r0 >= bits), 128'(1));
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_sclk"}, 128'(bus_a.sclk), 128'(0));
        chk({tag, "_mosi"}, 128'(bus_a.mosi), 128'(0));
        chk({tag, "_ss_n"}, 128'(bus_a.ss_n), 128'(1));
        chk({tag, "_busy"}, 128'(bus_a.busy), 128'(0));
        chk({tag, "_done"}, 128'(bus_a.done), 128'(0));
        chk({tag, "_err"},  128'(bus_a.err),  128'(0));
        chk({tag, "_rx"},   bus_a.rx_data,    128'(0));
        chk({tag, "_led"},  128'(bus_a.led),  128'(0));
    endtask

    task automatic start_a(input logic [3:0] nk, input logic [127:0] data, output int t0);
        bus_a.nk      = nk;
        bus_a.data_in = data;
        bus_a.key_in  = KEY;
        bus_a.start   = 1'b1;
        t0 = cyc;
        tick();
        bus_a.start = 1'b0;
    endtask

    initial begin
        int t0;
        int base;
        int r0;
        int l0;
        int ta;

        reset         = 1'b0;
        miso_mode_a   = 2'd0;
        bus_a.start   = 1'b0;
        bus_a.abort   = 1'b0;
        bus_a.nk      = 4'd0;
        bus_a.data_in = '0;
        bus_a.key_in  = '0;
        bus_b.start   = 1'b0;
        bus_b.abort   = 1'b0;
        bus_b.nk      = 4'd0;
        bus_b.data_in = '0;
        bus_b.key_in  = '0;

        fork
            mon(1'b0);
            mon(1'b1);
        join_none

        repeat (3) tick();
        chk_reset_a("rst");
        chk("rst_b_ss_n", 128'(bus_b.ss_n), 128'(1));
        chk("rst_b_busy", 128'(bus_b.busy), 128'(0));
        reset = 1'b1;
        tick();

        // nk=4 with loopback: rx ends up holding the 128 key bits
        miso_mode_a = 2'd0;
        base = ev_a;
        r0   = rise_a;
        q_a.push_back('{is_err: 1'b0, rx: RX_K4, led: 1'b1});
        start_a(NK_128, DATA1, t0);
        chk("t1_c1_ss_n", 128'(bus_a.ss_n), 128'(0));
        chk("t1_c1_busy", 128'(bus_a.busy), 128'(1));
        chk("t1_c1_mosi", 128'(bus_a.mosi), 128'(0));
        chk("t1_c1_sclk", 128'(bus_a.sclk), 128'(0));
        tick();
        chk("t1_c2_sclk", 128'(bus_a.sclk), 128'(0));
        tick();
        chk("t1_c3_sclk", 128'(bus_a.sclk), 128'(1));
        wait_ev(1'b0, base, 3000, "t1");
        chk("t1_done_cycle", 128'(ev_cyc_a - t0), 128'(1027));
        chk("t1_rises", 128'(rise_a - r0), 128'(256));
        chk("t1_ss_n_after", 128'(bus_a.ss_n), 128'(1));
        chk("t1_busy_after", 128'(bus_a.busy), 128'(0));

        // nk=8, miso high: all-ones capture, ss_n low 2*384*2+2 cycles
        miso_mode_a = 2'd1;
        base = ev_a;
        r0   = rise_a;
        l0   = low_a;
        q_a.push_back('{is_err: 1'b0, rx: ONES, led: 1'b1});
        start_a(NK_256, {16{8'hA5}}, t0);
        chk("t2_c1_mosi", 128'(bus_a.mosi), 128'(1));
        repeat (3) tick();
        chk("t2_c4_mosi", 128'(bus_a.mosi), 128'(1));
        tick();
        chk("t2_c5_mosi", 128'(bus_a.mosi), 128'(0));
        wait_ev(1'b0, base, 4000, "t2");
        chk("t2_rises", 128'(rise_a - r0), 128'(384));
        chk("t2_ss_low", 128'(low_a - l0), 128'(1538));

        // Illegal nk values: err one cycle after start, no frame
        r0 = rise_a;
        base = ev_a;
        q_a.push_back('{is_err: 1'b1, rx: ONES, led: 1'b0});
        start_a(4'd5, DATA1, t0);
        chk("t3_nk5_ss_n", 128'(bus_a.ss_n), 128'(1));
        chk("t3_nk5_busy", 128'(bus_a.busy), 128'(0));
        wait_ev(1'b0, base, 5, "t3_nk5");
        chk("t3_nk5_err_cycle", 128'(ev_cyc_a - t0), 128'(1));
        base = ev_a;
        q_a.push_back('{is_err: 1'b1, rx: ONES, led: 1'b0});
        start_a(4'd0, DATA1, t0);
        wait_ev(1'b0, base, 5, "t3_nk0");
        chk("t3_nk0_err_cycle", 128'(ev_cyc_a - t0), 128'(1));
        repeat (5) tick();
        chk("t3_ss_n", 128'(bus_a.ss_n), 128'(1));
        chk("t3_rises", 128'(rise_a - r0), 128'(0));
        chk("t3_led", 128'(bus_a.led), 128'(0));

        // nk=6 aborted after 100 bits; miso low so a wrong capture would show
        miso_mode_a = 2'd2;
        base = ev_a;
        r0   = rise_a;
        q_a.push_back('{is_err: 1'b1, rx: ONES, led: 1'b0});
        start_a(NK_192, DATA1, t0);
        wait_rise_a(r0, 100, "t4_reach_bit100");
        bus_a.abort = 1'b1;
        ta = cyc;
        tick();
        bus_a.abort = 1'b0;
        chk("t4_ab_ss_n", 128'(bus_a.ss_n), 128'(1));
        chk("t4_ab_sclk", 128'(bus_a.sclk), 128'(0));
        chk("t4_ab_mosi", 128'(bus_a.mosi), 128'(0));
        chk("t4_ab_busy", 128'(bus_a.busy), 128'(0));
        wait_ev(1'b0, base, 5, "t4_abort");
        chk("t4_err_cycle", 128'(ev_cyc_a - ta), 128'(1));
        repeat (20) tick();
        chk("t4_idle_after", 128'(bus_a.busy), 128'(0));

        miso_mode_a = 2'd0;
        base = ev_a;
        r0   = rise_a;
        q_a.push_back('{is_err: 1'b0, rx: RX_K6, led: 1'b1});
        start_a(NK_192, DATA1, t0);
        wait_ev(1'b0, base, 3000, "t4_restart");
        chk("t4_rises", 128'(rise_a - r0), 128'(320));

        // Reset at bit 200 with start held: reset values, no resume
        r0 = rise_a;
        start_a(NK_256, DATA1, t0);
        wait_rise_a(r0, 200, "t5_reach_bit200");
        reset       = 1'b0;
        bus_a.start = 1'b1;
        tick();
        chk_reset_a("t5");
        repeat (3) tick();
        reset       = 1'b1;
        bus_a.start = 1'b0;
        r0 = rise_a;
        repeat (10) tick();
        chk("t5_ss_n_idle", 128'(bus_a.ss_n), 128'(1));
        chk("t5_busy_idle", 128'(bus_a.busy), 128'(0));
        chk("t5_no_rises", 128'(rise_a - r0), 128'(0));

        // CLK_DIV=1: abort with start in IDLE is ignored; start/nk/key churn mid-frame
        base = ev_b;
        r0   = rise_b;
        q_b.push_back('{is_err: 1'b0, rx: RX_K6, led: 1'b1});
        bus_b.nk      = NK_192;
        bus_b.data_in = DATA1;
        bus_b.key_in  = KEY;
        bus_b.start   = 1'b1;
        bus_b.abort   = 1'b1;
        t0 = cyc;
        tick();
        bus_b.abort = 1'b0;
        chk("t6_c1_busy", 128'(bus_b.busy), 128'(1));
        chk("t6_c1_ss_n", 128'(bus_b.ss_n), 128'(0));
        bus_b.nk      = NK_128;
        bus_b.data_in = ~DATA1;
        bus_b.key_in  = ~KEY;
        repeat (10) tick();
        bus_b.start = 1'b0;
        wait_ev(1'b1, base, 2000, "t6");
        chk("t6_done_cycle", 128'(ev_cyc_b - t0), 128'(642));
        chk("t6_rises", 128'(rise_b - r0), 128'(320));
        repeat (10) tick();
        chk("t6_busy_after", 128'(bus_b.busy), 128'(0));

        chk("q_a_drained", 128'(q_a.size()), 128'(0));
        chk("q_b_drained", 128'(q_b.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
